result_write_arbiter: RTL and testbench

RESULT_WRITE_ARBITER -- requirements
Module: result_write_arbiter

---
 rtl/result_write_arbiter.sv | 128 ++++++++++++
 tb/tb_result_write_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/result_write_arbiter.sv
// rtl/result_write_arbiter.sv - round-robin arbiter writing 3 requesters' results into a circular slot buffer
module result_write_arbiter #(
  parameter int unsigned NUM_SLOTS   = 5,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] ADDR_STRIDE = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [95:0] req_data,
  output logic [2:0]  gnt,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [1:0]  wr_src,
  input  logic        rd_done,
  output logic [31:0] rd_addr,
  output logic [2:0]  count,
  output logic        full,
  output logic        empty,
  output logic        underflow_err
);

  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [2:0]       r_count;
  logic [1:0]       r_prio;
  logic             r_uerr;
  logic [2:0]       r_gnt;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic [1:0]       r_wr_src;

  logic [1:0]  w_winner;
  logic [1:0]  w_prio_next;
  logic        w_full;
  logic        w_empty;
  logic        w_write;
  logic        w_rd_valid;
  logic [31:0] w_wr_addr;

  // Upward search from the priority pointer, wrapping 2 -> 0
  always_comb begin
    w_winner = 2'd0;
    case (r_prio)
      2'd0:    w_winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      2'd1:    w_winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      default: w_winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
    endcase
  end

  assign w_prio_next = (w_winner == 2'd2) ? 2'd0 : w_winner + 2'd1;
  assign w_full      = (r_count == 3'(NUM_SLOTS));
  assign w_empty     = (r_count == 3'd0);
  assign w_write     = (r_state == WRITE);
  assign w_rd_valid  = rd_done && !w_empty;
  assign w_wr_addr   = ADDR_BASE + 32'(r_wr_ptr) * ADDR_STRIDE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= 3'd0;
      r_prio    <= 2'd0;
      r_uerr    <= 1'b0;
      r_gnt     <= 3'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 32'd0;
      r_wr_data <= 32'd0;
      r_wr_src  <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((req != 3'd0) && !w_full) begin
            r_state   <= WRITE;
            r_gnt     <= 3'd1 << w_winner;
            r_wr_en   <= 1'b1;
            r_wr_src  <= w_winner;
            r_wr_data <= req_data[{w_winner, 5'd0} +: 32];
            r_wr_addr <= w_wr_addr;
            r_prio    <= w_prio_next;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_gnt     <= 3'd0;
          r_wr_en   <= 1'b0;
          r_wr_src  <= 2'd0;
          r_wr_data <= 32'd0;
          r_wr_addr <= 32'd0;
          r_wr_ptr  <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
        end
      endcase

      if (w_rd_valid)
        r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
      if (rd_done && w_empty)
        r_uerr <= 1'b1;

      // A write completing alongside a valid free leaves occupancy unchanged
      case ({w_write, w_rd_valid})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign wr_src        = r_wr_src;
  assign rd_addr       = ADDR_BASE + 32'(r_rd_ptr) * ADDR_STRIDE;
  assign count         = r_count;
  assign full          = w_full;
  assign empty         = w_empty;
  assign underflow_err = r_uerr;

endmodule

// File: tb/tb_result_write_arbiter.sv
// tb/tb_result_write_arbiter.sv - vector table plus randomized reference-model check of result_write_arbiter
module tb_result_write_arbiter;

  localparam int NS = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [95:0] req_data;
  logic        rd_done;
  logic [2:0]  gnt;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_src;
  logic [31:0] rd_addr;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        underflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  result_write_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src),
    .rd_done(rd_done), .rd_addr(rd_addr), .count(count), .full(full),
    .empty(empty), .underflow_err(underflow_err)
  );

  localparam logic [95:0] RD = {32'hC2C2_0002, 32'hA5A5_0001, 32'hA0A0_0000};

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        rd;
    logic [2:0]  gnt;
    logic [31:0] addr;
    logic [2:0]  cnt;
    logic [31:0] rdaddr;
    logic        err;
  } vec_t;

  vec_t vt[$];

  // Reference model state: occupancy and indices as plain integers
  bit          m_pend;
  int          m_src;
  logic [31:0] m_data;
  logic [31:0] m_addr;
  int          m_cnt, m_wi, m_ri, m_prio;
  bit          m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] q, input logic rd, input logic [2:0] g,
                     input logic [31:0] a, input logic [2:0] c, input logic [31:0] ra, input logic e);
    vec_t v;
    v.rst = r; v.req = q; v.rd = rd; v.gnt = g; v.addr = a; v.cnt = c; v.rdaddr = ra; v.err = e;
    vt.push_back(v);
  endtask

  task automatic model_step(input logic r, input logic [2:0] q, input logic [95:0] d, input logic rd);
    bit wrote, rdv, found;
    int w;
    if (r) begin
      m_pend = 0; m_cnt = 0; m_wi = 0; m_ri = 0; m_prio = 0; m_err = 0;
      return;
    end
    wrote = m_pend;
    rdv = rd && (m_cnt > 0);
    if (rd && m_cnt == 0) m_err = 1;
    m_pend = 0;
    if (!wrote && q != 3'd0 && m_cnt != NS) begin
      found = 0; w = 0;
      for (int k = 0; k < 3; k++)
        if (!found && q[(m_prio + k) % 3]) begin found = 1; w = (m_prio + k) % 3; end
      m_pend = 1; m_src = w;
      m_data = d[w*32 +: 32];
      m_addr = 32'(m_wi * 4);
      m_prio = (w + 1) % 3;
    end
    if (wrote) m_wi = (m_wi + 1) % NS;
    if (rdv) m_ri = (m_ri + 1) % NS;
    m_cnt = m_cnt + int'(wrote) - int'(rdv);
  endtask

  task automatic cyc(input logic r, input logic [2:0] q, input logic [95:0] d, input logic rd);
    rst = r; req = q; req_data = d; rd_done = rd;
    @(posedge clk);
    model_step(r, q, d, rd);
    #1;
  endtask

  task automatic check_model();
    chk("m_wr_en", 32'(wr_en), 32'(m_pend));
    chk("m_gnt", 32'(gnt), m_pend ? (32'd1 << m_src) : 32'd0);
    chk("m_wr_src", 32'(wr_src), m_pend ? 32'(m_src) : 32'd0);
    chk("m_wr_addr", wr_addr, m_pend ? m_addr : 32'd0);
    chk("m_wr_data", wr_data, m_pend ? m_data : 32'd0);
    chk("m_count", 32'(count), 32'(m_cnt));
    chk("m_rd_addr", rd_addr, 32'(m_ri * 4));
    chk("m_full", 32'(full), 32'(m_cnt == NS));
    chk("m_empty", 32'(empty), 32'(m_cnt == 0));
    chk("m_uerr", 32'(underflow_err), 32'(m_err));
  endtask

  initial begin
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
    logic [95:0] rdat;
    logic [2:0]  rq;
    rst = 1'b1; req = 3'd0; req_data = 96'd0; rd_done = 1'b0;

    //  rst req    rd gnt     addr cnt rd_addr err
    add(1, 3'b000, 0, 3'b000,  0,  0,  0, 0);
    add(0, 3'b010, 0, 3'b010,  0,  0,  0, 0);   // single request
    add(0, 3'b000, 0, 3'b000,  0,  1,  0, 0);
    add(1, 3'b000, 0, 3'b000,  0,  0,  0, 0);
    add(0, 3'b111, 0, 3'b001,  0,  0,  0, 0);   // fairness + fill
    add(0, 3'b111, 0, 3'b000,  0,  1,  0, 0);
    add(0, 3'b111, 0, 3'b010,  4,  1,  0, 0);
    add(0, 3'b111, 0, 3'b000,  0,  2,  0, 0);
    add(0, 3'b111, 0, 3'b100,  8,  2,  0, 0);
    add(0, 3'b111, 0, 3'b000,  0,  3,  0, 0);
    add(0, 3'b111, 0, 3'b001, 12,  3,  0, 0);
    add(0, 3'b111, 0, 3'b000,  0,  4,  0, 0);
    add(0, 3'b111, 0, 3'b010, 16,  4,  0, 0);
    add(0, 3'b111, 0, 3'b000,  0,  5,  0, 0);
    add(0, 3'b111, 0, 3'b000,  0,  5,  0, 0);   // full blocks grant
    add(0, 3'b111, 1, 3'b000,  0,  4,  4, 0);
    add(0, 3'b111, 0, 3'b100,  0,  4,  4, 0);   // wrapped write
    add(0, 3'b000, 0, 3'b000,  0,  5,  4, 0);
    add(1, 3'b000, 0, 3'b000,  0,  0,  0, 0);
    add(0, 3'b001, 0, 3'b001,  0,  0,  0, 0);
    add(0, 3'b000, 0, 3'b000,  0,  1,  0, 0);
    add(0, 3'b001, 0, 3'b001,  4,  1,  0, 0);
    add(0, 3'b000, 0, 3'b000,  0,  2,  0, 0);
    add(0, 3'b100, 0, 3'b100,  8,  2,  0, 0);
    add(0, 3'b000, 1, 3'b000,  0,  2,  4, 0);   // write and free together
    add(1, 3'b000, 0, 3'b000,  0,  0,  0, 0);
    add(0, 3'b000, 1, 3'b000,  0,  0,  0, 1);   // underflow
    add(0, 3'b000, 0, 3'b000,  0,  0,  0, 1);
    add(0, 3'b010, 0, 3'b010,  0,  0,  0, 1);
    add(1, 3'b000, 0, 3'b000,  0,  0,  0, 0);   // reset aborts write
    add(0, 3'b000, 0, 3'b000,  0,  0,  0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].rst, vt[i].req, RD, vt[i].rd);
      exp_src  = vt[i].gnt[2] ? 2'd2 : (vt[i].gnt[1] ? 2'd1 : 2'd0);
      rdat     = RD;
      exp_data = (vt[i].gnt != 3'd0) ? rdat[exp_src*32 +: 32] : 32'd0;
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vt[i].gnt != 3'd0));
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      chk($sformatf("v%0d_wr_src", i), 32'(wr_src), (vt[i].gnt != 3'd0) ? 32'(exp_src) : 32'd0);
      chk($sformatf("v%0d_wr_addr", i), wr_addr, vt[i].addr);
      chk($sformatf("v%0d_wr_data", i), wr_data, exp_data);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_rd_addr", i), rd_addr, vt[i].rdaddr);
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].cnt == 3'd5));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].cnt == 3'd0));
      chk($sformatf("v%0d_uerr", i), 32'(underflow_err), 32'(vt[i].err));
    end

    cyc(1'b1, 3'd0, 96'd0, 1'b0);
    check_model();
    for (int n = 0; n < 3000; n++) begin
      rq   = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
      rdat = {$urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 99) == 0), rq, rdat, ($urandom_range(0, 9) < 3));
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
